game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 29 ++
 rtl/game_ctrl.sv | 166 ++++++++++++++++
 tb/tb_game_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Bundle between the game controller and the video/input front end.
// Signals:
//   i_pix_stb, i_animate      pixel strobe and end-of-frame pulse
//   i_px_dino, i_px_obst      current pixel inside dinosaur / any obstacle box
//   i_start                   raw jump/start button (not synchronized)
//   o_run, o_game_over        registered game state flags
//   o_score, o_hiscore        4-digit BCD score and best score since reset
// The master modport drives the inputs; the slave modport is the controller.
interface game_ctrl_if;
   logic        i_pix_stb;
   logic        i_animate;
   logic        i_px_dino;
   logic        i_px_obst;
   logic        i_start;
   logic        o_run;
   logic        o_game_over;
   logic [15:0] o_score;
   logic [15:0] o_hiscore;

   modport master (
      output i_pix_stb, i_animate, i_px_dino, i_px_obst, i_start,
      input  o_run, o_game_over, o_score, o_hiscore
   );

   modport slave (
      input  i_pix_stb, i_animate, i_px_dino, i_px_obst, i_start,
      output o_run, o_game_over, o_score, o_hiscore
   );
endinterface

// File: rtl/game_ctrl.sv
// Game controller: IDLE/RUN/OVER sequencing, collision latch, BCD score
// and hiscore keeping, restart holdoff after a game ends.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (released synchronously inside)
//   bus      game_ctrl_if.slave: frame/pixel inputs, start button, status
module game_ctrl #(
   parameter int unsigned SCORE_DIV = 6,
   parameter int unsigned HOLDOFF   = 30
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   game_ctrl_if.slave  bus
);

   localparam int unsigned FRAME_W = (SCORE_DIV < 1) ? 1 : $clog2(SCORE_DIV + 1);
   localparam int unsigned HOLD_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] OVER = 2'd2;

   logic               rst_meta, rst_sync_n;
   logic               start_s1, start_s2, start_s3;
   logic               fill_s1, fill_s2, armed;
   logic               start_evt_c, hit_px_c;
   logic [1:0]         state, state_nxt;
   logic               hit, hit_nxt;
   logic [FRAME_W-1:0] frame_cnt, frame_nxt;
   logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
   logic [15:0]        score, score_nxt;
   logic [15:0]        hiscore, hiscore_nxt;
   logic               run_q, over_q;

   // BCD +1 with per-digit carry, saturating at 9999
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = (v != 16'h9999);
      for (int d = 0; d < 4; d++) begin
         if (carry) begin
            if (r[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Reset: asserts immediately, releases on the second clock edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rst_meta   <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta   <= 1'b1;
         rst_sync_n <= rst_meta;
      end
   end

   // Button synchronizer plus edge detect. The fill pipe marks when start_s2
   // carries a real post-reset sample; a start is only armed once the button
   // has been seen released, so a press held through reset does not count.
   always_ff @(posedge i_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         start_s1 <= 1'b0;
         start_s2 <= 1'b0;
         start_s3 <= 1'b0;
         fill_s1  <= 1'b0;
         fill_s2  <= 1'b0;
         armed    <= 1'b0;
      end else begin
         start_s1 <= bus.i_start;
         start_s2 <= start_s1;
         start_s3 <= start_s2;
         fill_s1  <= 1'b1;
         fill_s2  <= fill_s1;
         armed    <= armed | (fill_s2 & ~start_s2);
      end
   end

   assign start_evt_c = armed & start_s2 & ~start_s3;
   assign hit_px_c    = bus.i_pix_stb & bus.i_px_dino & bus.i_px_obst;

   // State and datapath registers
   always_ff @(posedge i_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state     <= IDLE;
         hit       <= 1'b0;
         frame_cnt <= '0;
         hold_cnt  <= '0;
         score     <= '0;
         hiscore   <= '0;
         run_q     <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         hit       <= hit_nxt;
         frame_cnt <= frame_nxt;
         hold_cnt  <= hold_nxt;
         score     <= score_nxt;
         hiscore   <= hiscore_nxt;
         run_q     <= (state_nxt == RUN);
         over_q    <= (state_nxt == OVER);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt   = state;
      hit_nxt     = hit;
      frame_nxt   = frame_cnt;
      hold_nxt    = hold_cnt;
      score_nxt   = score;
      hiscore_nxt = hiscore;
      case (state)
         IDLE: begin
            if (start_evt_c) begin
               state_nxt = RUN;
               score_nxt = '0;
               hit_nxt   = 1'b0;
               frame_nxt = '0;
            end
         end
         RUN: begin
            if (bus.i_animate) begin
               // a hit in the same cycle as the frame pulse ends this frame
               if (hit | hit_px_c) begin
                  state_nxt = OVER;
                  hit_nxt   = 1'b0;
                  hold_nxt  = '0;
                  if (score > hiscore) hiscore_nxt = score;
               end else if (frame_cnt == FRAME_W'(SCORE_DIV - 1)) begin
                  frame_nxt = '0;
                  score_nxt = bcd_inc(score);
               end else begin
                  frame_nxt = frame_cnt + FRAME_W'(1);
               end
            end else if (hit_px_c) begin
               hit_nxt = 1'b1;
            end
         end
         OVER: begin
            if (start_evt_c && (hold_cnt == HOLD_W'(HOLDOFF))) begin
               state_nxt = RUN;
               score_nxt = '0;
               hit_nxt   = 1'b0;
               frame_nxt = '0;
            end else if (bus.i_animate && (hold_cnt != HOLD_W'(HOLDOFF))) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.o_run       = run_q;
   assign bus.o_game_over = over_q;
   assign bus.o_score     = score;
   assign bus.o_hiscore   = hiscore;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed stimulus, an event-level model of the game
// rules checked every cycle, and hand-computed literal expectations.
module tb_game_ctrl;
   localparam int unsigned SCORE_DIV = 6;
   localparam int unsigned HOLDOFF   = 30;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_OVER = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   game_ctrl_if bus ();

   game_ctrl #(.SCORE_DIV(SCORE_DIV), .HOLDOFF(HOLDOFF)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   // Model: score is completed clean frames / SCORE_DIV, hiscore the best final score
   int   m_mode, m_frames, m_anims, m_hi;
   logic m_hit, m_p1, m_p2, m_p3, m_released;
   logic m_ev, m_hit_now;
   int   m_cur;

   assign m_ev      = m_released & m_p2 & ~m_p3;
   assign m_hit_now = m_hit | (bus.i_pix_stb & bus.i_px_dino & bus.i_px_obst);
   assign m_cur     = m_frames / int'(SCORE_DIV);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= M_IDLE; m_frames <= 0; m_anims <= 0; m_hi <= 0;
         m_hit <= 1'b0; m_p1 <= 1'b0; m_p2 <= 1'b0; m_p3 <= 1'b0; m_released <= 1'b0;
      end else begin
         m_p1 <= bus.i_start; m_p2 <= m_p1; m_p3 <= m_p2;
         if (!bus.i_start) m_released <= 1'b1;
         case (m_mode)
            M_IDLE: if (m_ev) begin m_mode <= M_RUN; m_frames <= 0; m_hit <= 1'b0; end
            M_RUN: begin
               if (bus.i_animate) begin
                  if (m_hit_now) begin
                     m_mode <= M_OVER; m_hit <= 1'b0; m_anims <= 0;
                     if (m_cur > m_hi) m_hi <= m_cur;
                  end else begin
                     m_frames <= m_frames + 1;
                  end
               end else begin
                  m_hit <= m_hit_now;
               end
            end
            default: begin
               if (m_ev && m_anims >= int'(HOLDOFF)) begin
                  m_mode <= M_RUN; m_frames <= 0; m_hit <= 1'b0;
               end else if (bus.i_animate) begin
                  m_anims <= m_anims + 1;
               end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      check("model_run",   16'(bus.o_run),       16'(m_mode == M_RUN));
      check("model_over",  16'(bus.o_game_over), 16'(m_mode == M_OVER));
      check("model_score", bus.o_score,          to_bcd(m_cur));
      check("model_hi",    bus.o_hiscore,        to_bcd(m_hi));
   end

   task automatic anim(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk) #1 bus.i_animate = 1'b1;
         @(posedge clk) #1 bus.i_animate = 1'b0;
      end
   endtask

   task automatic anim_burst(input int n);
      @(posedge clk) #1 bus.i_animate = 1'b1;
      repeat (n) @(posedge clk);
      #1 bus.i_animate = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk) #1 bus.i_start = 1'b1;
      @(posedge clk) #1 bus.i_start = 1'b0;
   endtask

   initial begin
      bus.i_pix_stb = 1'b0; bus.i_animate = 1'b0; bus.i_px_dino = 1'b0;
      bus.i_px_obst = 1'b0; bus.i_start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_run", 16'(bus.o_run), 16'h0);
      check("rst_over", 16'(bus.o_game_over), 16'h0);
      check("rst_score", bus.o_score, 16'h0000);
      check("rst_hi", bus.o_hiscore, 16'h0000);
      @(posedge clk) #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);

      // start latency: two synchronizer cycles plus the output register
      #1 bus.i_start = 1'b1;
      @(posedge clk) #1 bus.i_start = 1'b0;
      @(posedge clk);
      @(negedge clk) check("start_lat2", 16'(bus.o_run), 16'h0);
      @(posedge clk);
      @(negedge clk) check("start_lat3", 16'(bus.o_run), 16'h1);
      check("start_score", bus.o_score, 16'h0000);

      anim(12);
      @(negedge clk) check("score_12", bus.o_score, 16'h0002);
      anim(6);
      @(negedge clk) check("score_18", bus.o_score, 16'h0003);
      anim(21);
      @(negedge clk) check("score_39", bus.o_score, 16'h0006);

      // hit latched mid-frame, game ends at the next frame pulse
      @(posedge clk) #1 begin bus.i_pix_stb = 1'b1; bus.i_px_dino = 1'b1; bus.i_px_obst = 1'b1; end
      @(posedge clk) #1 begin bus.i_pix_stb = 1'b0; bus.i_px_dino = 1'b0; bus.i_px_obst = 1'b0; end
      repeat (3) @(posedge clk);
      @(negedge clk) check("hit_waits_frame", 16'(bus.o_run), 16'h1);
      anim(1);
      @(negedge clk);
      check("over_flag", 16'(bus.o_game_over), 16'h1);
      check("over_run", 16'(bus.o_run), 16'h0);
      check("over_score", bus.o_score, 16'h0006);
      check("over_hi", bus.o_hiscore, 16'h0006);

      // holdoff: restart ignored at 10 and 29 animates, accepted at 30
      anim(10); pulse_start(); repeat (5) @(posedge clk);
      @(negedge clk) check("holdoff_10", 16'(bus.o_game_over), 16'h1);
      anim(19); pulse_start(); repeat (5) @(posedge clk);
      @(negedge clk) check("holdoff_29", 16'(bus.o_game_over), 16'h1);
      anim(1); pulse_start(); repeat (5) @(posedge clk);
      @(negedge clk);
      check("restart_run", 16'(bus.o_run), 16'h1);
      check("restart_score", bus.o_score, 16'h0000);
      check("restart_hi", bus.o_hiscore, 16'h0006);

      // lower second game, hit coinciding with the frame pulse
      anim(20);
      @(posedge clk) #1 begin
         bus.i_animate = 1'b1; bus.i_pix_stb = 1'b1; bus.i_px_dino = 1'b1; bus.i_px_obst = 1'b1;
      end
      @(posedge clk) #1 begin
         bus.i_animate = 1'b0; bus.i_pix_stb = 1'b0; bus.i_px_dino = 1'b0; bus.i_px_obst = 1'b0;
      end
      @(negedge clk);
      check("g2_over", 16'(bus.o_game_over), 16'h1);
      check("g2_score", bus.o_score, 16'h0003);
      check("g2_hi", bus.o_hiscore, 16'h0006);

      // BCD carry and saturation
      anim_burst(30); pulse_start(); repeat (5) @(posedge clk);
      @(negedge clk) check("g3_run", 16'(bus.o_run), 16'h1);
      anim_burst(5994);
      @(negedge clk) check("score_0999", bus.o_score, 16'h0999);
      anim_burst(6);
      @(negedge clk) check("score_1000", bus.o_score, 16'h1000);
      anim_burst(53994);
      @(negedge clk) check("score_9999", bus.o_score, 16'h9999);
      anim_burst(12);
      @(negedge clk) check("score_sat", bus.o_score, 16'h9999);

      // asynchronous reset mid-RUN, button held through release
      @(posedge clk) #3 begin rst_n = 1'b0; bus.i_start = 1'b1; end
      #1;
      check("async_run", 16'(bus.o_run), 16'h0);
      check("async_score", bus.o_score, 16'h0000);
      check("async_hi", bus.o_hiscore, 16'h0000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk) check("held_start", 16'(bus.o_run), 16'h0);
      @(posedge clk) #1 bus.i_start = 1'b0;
      repeat (5) @(posedge clk);
      pulse_start();
      @(posedge clk);
      @(negedge clk) check("repress_lat2", 16'(bus.o_run), 16'h0);
      @(posedge clk);
      @(negedge clk) check("repress_lat3", 16'(bus.o_run), 16'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
